// File: rtl/chimera_pkg.sv
// chimera_pkg: shared types and helpers for the cluster power sequencer
package chimera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PD_ISO,
    PD_GATE,
    PD_RST,
    PU_CLK,
    PU_RST,
    PU_DEISO,
    PU_DONE
  } clu_pwr_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_rr_arb.sv
// chimera_clu_pwr_rr_arb: round-robin pick of the first pending cluster after the pointer
module chimera_clu_pwr_rr_arb #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [IW-1:0] w_j;

  // scan offsets from farthest to nearest so the nearest pending index after the pointer wins
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_pend[w_j]) begin
        o_idx   = w_j;
        o_valid = 1'b1;
      end
    end
    o_gnt = o_valid ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// chimera_clu_pwr_seq: one-at-a-time power/isolation sequencer for the external clusters
module chimera_clu_pwr_seq
  import chimera_pkg::*;
#(
  parameter int NumClusters   = 5,
  parameter int RstCycles     = 8,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] clu_en_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clu_clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] clu_on_o,
  output logic                   busy_o,
  output logic [NumClusters-1:0] err_o,
  input  logic [NumClusters-1:0] err_clr_i
);

  localparam int IW = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int CW = $clog2(max3(RstCycles, SettleCycles, TimeoutCycles)) + 1;
  localparam logic [CW-1:0] RstLast = CW'(RstCycles - 1);
  localparam logic [CW-1:0] SetLast = CW'(SettleCycles - 1);
  localparam logic [CW-1:0] ToLast  = CW'(TimeoutCycles - 1);

  clu_pwr_state_e r_state, w_state_d;
  logic [IW-1:0] r_ptr, r_sel, w_idx;
  logic [CW-1:0] r_cnt;
  logic [NumClusters-1:0] r_iso, r_clk_en, r_rst_n, r_on, r_err;
  logic [NumClusters-1:0] w_pend, w_gnt, w_oh;
  logic r_busy, w_valid, w_on_sel, w_iso_sel, w_to, w_enter;

  assign w_pend    = clu_en_i ^ r_on;
  assign w_oh      = (r_state == IDLE) ? w_gnt : (NumClusters'(1) << r_sel);
  assign w_on_sel  = |(r_on & w_oh);
  assign w_iso_sel = |(isolated_i & w_oh);
  assign w_enter   = w_state_d != r_state;

  chimera_clu_pwr_rr_arb #(
    .N  (NumClusters),
    .IW (IW)
  ) u_arb (
    .i_pend  (w_pend),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  // next-state logic; a handshake wait that ends on the counter flags a timeout
  always_comb begin
    w_state_d = r_state;
    w_to      = 1'b0;
    case (r_state)
      IDLE:     if (w_valid) w_state_d = w_on_sel ? PD_ISO : PU_CLK;
      PD_ISO:   if (w_iso_sel || r_cnt == ToLast) begin
                  w_state_d = PD_GATE;
                  w_to      = !w_iso_sel;
                end
      PD_GATE:  if (r_cnt == SetLast) w_state_d = PD_RST;
      PD_RST:   w_state_d = IDLE;
      PU_CLK:   if (r_cnt == RstLast) w_state_d = PU_RST;
      PU_RST:   if (r_cnt == SetLast) w_state_d = PU_DEISO;
      PU_DEISO: if (!w_iso_sel || r_cnt == ToLast) begin
                  w_state_d = PU_DONE;
                  w_to      = w_iso_sel;
                end
      default:  w_state_d = IDLE;
    endcase
  end

  // shared dwell counter, latched grant and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_sel <= '0;
      r_ptr <= IW'(NumClusters - 1);
    end else begin
      r_cnt <= (w_enter || w_state_d == IDLE) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && w_valid) r_sel <= w_idx;
      if (r_state != IDLE && w_state_d == IDLE) r_ptr <= r_sel;
    end
  end

  // cluster controls change only for the selected cluster, on entry to each state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_iso    <= '1;
      r_clk_en <= '0;
      r_rst_n  <= '0;
      r_on     <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= w_state_d != IDLE;
      r_err  <= (r_err & ~err_clr_i) | (w_to ? w_oh : '0);
      if (w_enter) begin
        case (w_state_d)
          PD_ISO:   r_iso    <= r_iso | w_oh;
          PD_GATE:  r_clk_en <= r_clk_en & ~w_oh;
          PD_RST:   begin
                      r_rst_n <= r_rst_n & ~w_oh;
                      r_on    <= r_on & ~w_oh;
                    end
          PU_CLK:   r_clk_en <= r_clk_en | w_oh;
          PU_RST:   r_rst_n  <= r_rst_n | w_oh;
          PU_DEISO: r_iso    <= r_iso & ~w_oh;
          PU_DONE:  r_on     <= r_on | w_oh;
          default:  ;
        endcase
      end
    end
  end

  assign isolate_o    = r_iso;
  assign clu_clk_en_o = r_clk_en;
  assign clu_rst_no   = r_rst_n;
  assign clu_on_o     = r_on;
  assign err_o        = r_err;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// tb_chimera_clu_pwr_seq: event-scoreboard bench for the cluster power sequencer
module tb_chimera_clu_pwr_seq;

  localparam int N = 5;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [N-1:0] clu_en_i = '0;
  logic [N-1:0] err_clr_i = '0;
  logic [N-1:0] isolated_i;
  logic [N-1:0] isolate_o, clu_clk_en_o, clu_rst_no, clu_on_o, err_o;
  logic busy_o;

  chimera_clu_pwr_seq #(
    .NumClusters   (N),
    .RstCycles     (8),
    .SettleCycles  (4),
    .TimeoutCycles (1024)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clu_en_i     (clu_en_i),
    .isolated_i   (isolated_i),
    .isolate_o    (isolate_o),
    .clu_clk_en_o (clu_clk_en_o),
    .clu_rst_no   (clu_rst_no),
    .clu_on_o     (clu_on_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // isolation wrapper model: status echoes the request three cycles later; hold_lo pins a status low
  logic [N-1:0] d1 = '1, d2 = '1, d3 = '1, hold_lo = '0;
  always @(posedge clk_i) begin
    d1 <= isolate_o;
    d2 <= d1;
    d3 <= d2;
  end
  assign isolated_i = d3 & ~hold_lo;

  // kind: 0 isolate_o, 1 clu_clk_en_o, 2 clu_rst_no, 3 clu_on_o; dly = cycles since previous event, -1 = unchecked
  typedef struct {int kind; int idx; int val; int dly;} evt_t;
  evt_t q[$];
  int errors = 0, checks = 0, last_cyc = 0;
  bit mon_en = 1'b0;
  logic [N-1:0] prev [4];

  function automatic logic [N-1:0] sig(input int k);
    return (k == 0) ? isolate_o : (k == 1) ? clu_clk_en_o : (k == 2) ? clu_rst_no : clu_on_o;
  endfunction

  task automatic push(input int k, input int c, input int v, input int d);
    evt_t e;
    e.kind = k; e.idx = c; e.val = v; e.dly = d;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input int k, input int c, input int v);
    evt_t e;
    int obs, exp;
    checks++;
    assert (q.size() != 0) else begin
      errors++;
      $error("FAIL evt_unexpected observed kind=%0d idx=%0d val=%0d expected no event", k, c, v);
    end
    if (q.size() == 0) return;
    e = q.pop_front();
    obs = k * 100 + c * 10 + v;
    exp = e.kind * 100 + e.idx * 10 + e.val;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL evt_order observed=%0d expected=%0d (kind*100+idx*10+val)", obs, exp);
    end
    if (e.dly >= 0) begin
      checks++;
      assert (cyc - last_cyc === e.dly) else begin
        errors++;
        $error("FAIL evt_delay kind=%0d idx=%0d observed=%0d expected=%0d", k, c, cyc - last_cyc, e.dly);
      end
    end
    last_cyc = cyc;
  endtask

  // monitor: every output bit change must match the next scoreboard entry
  initial begin
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < 4; k++) begin
        logic [N-1:0] cur;
        cur = sig(k);
        if (mon_en)
          for (int c = 0; c < N; c++)
            if (cur[c] !== prev[k][c]) check_evt(k, c, int'(cur[c]));
        prev[k] = cur;
      end
    end
  end

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while ((q.size() != 0 || busy_o) && n < lim) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic push_pu(input int c, input int d0);
    push(1, c, 1, d0); push(2, c, 1, 8); push(0, c, 0, 4); push(3, c, 1, 4);
  endtask

  task automatic push_pd(input int c, input int d0, input int iso_wait);
    push(0, c, 1, d0); push(1, c, 0, iso_wait); push(2, c, 0, 4); push(3, c, 0, 0);
  endtask

  task automatic pulse_rst();
    mon_en = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_i);
    chk("rst_iso", isolate_o, 5'b11111);
    chk("rst_clk", clu_clk_en_o, 0);
    chk("rst_rstn", clu_rst_no, 0);
    chk("rst_on", clu_on_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    mon_en = 1'b1;

    clu_en_i = 5'b00001;
    push_pu(0, -1);
    drain("pu0", 100);
    chk("pu0_on", clu_on_o, 5'b00001);
    chk("pu0_iso", isolate_o, 5'b11110);
    chk("pu0_err", err_o, 0);

    clu_en_i = 5'b00000;
    push_pd(0, -1, 4);
    drain("pd0", 100);
    chk("pd0_on", clu_on_o, 0);
    chk("pd0_iso", isolate_o, 5'b11111);

    pulse_rst();
    clu_en_i = 5'b11111;
    for (int c = 0; c < N; c++) push_pu(c, (c == 0) ? -1 : 2);
    repeat (4) @(negedge clk_i);
    chk("all_busy", busy_o, 1);
    drain("pu_all", 400);
    chk("pu_all_on", clu_on_o, 5'b11111);
    chk("pu_all_rstn", clu_rst_no, 5'b11111);

    clu_en_i = 5'b11011;
    push_pd(2, -1, 4);
    drain("pd2", 100);

    clu_en_i = 5'b01001;
    push_pd(4, -1, 4);
    push_pd(1, 2, 4);
    drain("wrap", 200);
    chk("wrap_on", clu_on_o, 5'b01001);

    hold_lo = 5'b01000;
    clu_en_i = 5'b00001;
    push_pd(3, -1, 1024);
    repeat (100) @(negedge clk_i);
    chk("to_mid_err", err_o, 0);
    chk("to_mid_busy", busy_o, 1);
    drain("to", 1200);
    chk("to_err", err_o, 5'b01000);
    chk("to_on", clu_on_o, 5'b00001);
    err_clr_i = 5'b01000;
    @(negedge clk_i);
    err_clr_i = '0;
    chk("to_err_clr", err_o, 0);
    hold_lo = '0;

    clu_en_i = 5'b00101;
    push_pu(2, -1);
    push_pd(2, 2, 4);
    repeat (3) @(negedge clk_i);
    clu_en_i = 5'b00001;
    drain("defer", 300);
    chk("defer_on", clu_on_o, 5'b00001);

    clu_en_i = 5'b00101;
    push(1, 2, 1, -1);
    n = 0;
    while (clu_clk_en_o[2] !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("midrst_start", clu_clk_en_o[2], 1);
    repeat (2) @(negedge clk_i);
    chk("midrst_pre_busy", busy_o, 1);
    mon_en = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midrst_iso", isolate_o, 5'b11111);
    chk("midrst_clk", clu_clk_en_o, 0);
    chk("midrst_rstn", clu_rst_no, 0);
    chk("midrst_on", clu_on_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_left", q.size(), 0);
    clu_en_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("post_busy", busy_o, 0);
    chk("post_clk", clu_clk_en_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
